sgen_phase_ctrl: RTL and testbench

Phase-generation and sequencing stage directly upstream of `sgen_cordic`: a phase accumulator driven by a frequency control word produces one phase per sample. Each phase is folded into the CORDIC convergence range [-pi/2, pi/2] and converted to a Q2.14 radian angle. The block starts the iterative CORDIC, waits for its done flag, then applies the quadrant sign correction to the returned x/y to emit one sin/cos sample with a valid strobe.

---
 rtl/sgen_pkg.sv | 18 +
 rtl/sgen_lfsr.sv | 26 ++
 rtl/sgen_phase_ctrl.sv | 146 ++++++++++++++
 tb/tb_sgen_phase_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgen_pkg.sv
// Shared types and constants for the sine-generator phase/sequencing stage.
// Optional phase dither is enabled with SGEN_PHASE_DITHER_EN.
package sgen_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_OUT
    } sgen_state_t;

    localparam int PI_HALF_Q15 = 51472;

    // Fibonacci taps 16,14,13,11 as bit indices 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/sgen_lfsr.sv
// 16-bit Fibonacci LFSR used as the phase dither source.
// Steps once per asserted step cycle; synchronous active-low reset to seed.
module sgen_lfsr
    import sgen_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_an,
    input  logic        i_step,
    output logic [15:0] o_q
);

    logic [15:0] q;
    logic        fb;

    assign fb  = ^(q & LFSR_TAPS);
    assign o_q = q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            q <= LFSR_SEED;
        end else if (i_step) begin
            q <= {q[14:0], fb};
        end
    end

endmodule

// File: rtl/sgen_phase_ctrl.sv
// Phase accumulator, quadrant fold and CORDIC sequencing for sgen_cordic.
// Define SGEN_PHASE_DITHER_EN to add LFSR dither before phase truncation.
module sgen_phase_ctrl
    import sgen_pkg::*;
#(
    parameter int gp_acc_width   = 32,
    parameter int gp_phase_width = 16,
    parameter int gp_xy_width    = 24,
    parameter int gp_z_width     = 16,
    parameter int gp_amp         = 4194304
) (
    input  logic                    i_clk,
    input  logic                    i_rst_an,
    input  logic                    i_ena,
    input  logic [gp_acc_width-1:0] i_fcw,
    output logic [gp_xy_width-1:0]  o_cordic_x,
    output logic [gp_xy_width-1:0]  o_cordic_y,
    output logic [gp_z_width-1:0]   o_cordic_z,
    output logic                    o_cordic_start,
    input  logic [gp_xy_width-1:0]  i_cordic_x,
    input  logic [gp_xy_width-1:0]  i_cordic_y,
    input  logic                    i_cordic_done,
    output logic [gp_xy_width-1:0]  o_sin,
    output logic [gp_xy_width-1:0]  o_cos,
    output logic                    o_valid
);

    localparam int DW  = gp_acc_width - gp_phase_width;
    localparam int PW2 = gp_phase_width + 2;
    localparam int MW  = gp_phase_width + 18;

    localparam logic signed [PW2-1:0] QTR  = PW2'(1) << (gp_phase_width - 2);
    localparam logic signed [PW2-1:0] HALF = PW2'(1) << (gp_phase_width - 1);
    localparam logic signed [MW-1:0]  K    = MW'(PI_HALF_Q15);
    localparam logic signed [MW-1:0]  RND  = MW'(1) << 14;

    localparam logic [gp_xy_width-1:0] XMIN = {1'b1, {(gp_xy_width-1){1'b0}}};
    localparam logic [gp_xy_width-1:0] XMAX = ~XMIN;

    sgen_state_t state_q, state_d;

    logic [gp_acc_width-1:0]   acc_q;
    logic [gp_acc_width-1:0]   ph_src;
    logic [gp_phase_width-1:0] phase;
    logic signed [PW2-1:0]     pe, pf;
    logic signed [MW-1:0]      prod;
    logic [gp_z_width-1:0]     z_d, z_q;
    logic                      neg_d, neg_q;
    logic [gp_xy_width-1:0]    xneg;
    logic [gp_xy_width-1:0]    sin_q, cos_q;
    logic                      issue;

    assign issue = (state_q == S_IDLE) && i_ena;

`ifdef SGEN_PHASE_DITHER_EN
    localparam logic [gp_acc_width-1:0] DMASK =
        (gp_acc_width'(1) << DW) - gp_acc_width'(1);

    logic [15:0] lfsr_q;

    sgen_lfsr u_lfsr (
        .i_clk    (i_clk),
        .i_rst_an (i_rst_an),
        .i_step   (issue),
        .o_q      (lfsr_q)
    );

    assign ph_src = acc_q + (gp_acc_width'(lfsr_q) & DMASK);
`else
    assign ph_src = acc_q;
`endif

    assign phase = gp_phase_width'(ph_src >> DW);
    assign pe    = {{2{phase[gp_phase_width-1]}}, phase};

    // Fold into [-0.25, +0.25] turn; exactly +-0.25 stays unfolded
    always_comb begin
        pf    = pe;
        neg_d = 1'b0;
        if (pe > QTR) begin
            pf    = HALF - pe;
            neg_d = 1'b1;
        end else if (pe < -QTR) begin
            pf    = -HALF - pe;
            neg_d = 1'b1;
        end
    end

    assign prod = pf * K;
    assign z_d  = gp_z_width'((prod + RND) >>> 15);
    assign xneg = (i_cordic_x == XMIN) ? XMAX : -i_cordic_x;

    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        o_cordic_start = 1'b0;
        o_valid        = 1'b0;
        unique case (state_q)
            S_IDLE: if (i_ena) state_d = S_LOAD;
            S_LOAD: begin
                o_cordic_start = 1'b1;
                state_d        = S_WAIT;
            end
            S_WAIT: if (i_cordic_done) state_d = S_OUT;
            S_OUT: begin
                o_valid = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_an) begin
            acc_q <= '0;
            z_q   <= '0;
            neg_q <= 1'b0;
            sin_q <= '0;
            cos_q <= '0;
        end else begin
            if (issue) begin
                acc_q <= acc_q + i_fcw;
                z_q   <= z_d;
                neg_q <= neg_d;
            end
            if (state_q == S_WAIT && i_cordic_done) begin
                sin_q <= i_cordic_y;
                cos_q <= neg_q ? xneg : i_cordic_x;
            end
        end
    end

    assign o_cordic_x = gp_xy_width'(gp_amp);
    assign o_cordic_y = '0;
    assign o_cordic_z = z_q;
    assign o_sin      = sin_q;
    assign o_cos      = cos_q;

endmodule

// File: tb/tb_sgen_phase_ctrl.sv
// Scoreboard bench for sgen_phase_ctrl with a fixed-latency CORDIC stub.
// Dithered builds (SGEN_PHASE_DITHER_EN) relax the angle check to a small window.
module tb_sgen_phase_ctrl;

    localparam int LAT = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [31:0] fcw;
    logic [23:0] cx, cy, stub_x, stub_y;
    logic [15:0] cz;
    logic        cstart;
    logic        cdone;
    logic        force_done;
    logic [23:0] o_sin, o_cos;
    logic        o_valid;

    int tests = 0;
    int fails = 0;
    int n_start = 0;
    int n_valid = 0;
    int cyc = 0;
    int last_valid = -1;
    bit chk_period = 1'b0;
    int cnt = 0;

    int exp_z[$];
    int exp_sin[$];
    int exp_cos[$];

    always #5 clk = ~clk;

    sgen_phase_ctrl dut (
        .i_clk          (clk),
        .i_rst_an       (rst_n),
        .i_ena          (ena),
        .i_fcw          (fcw),
        .o_cordic_x     (cx),
        .o_cordic_y     (cy),
        .o_cordic_z     (cz),
        .o_cordic_start (cstart),
        .i_cordic_x     (stub_x),
        .i_cordic_y     (stub_y),
        .i_cordic_done  (cdone),
        .o_sin          (o_sin),
        .o_cos          (o_cos),
        .o_valid        (o_valid)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) cnt <= 0;
        else if (cstart) cnt <= LAT;
        else if (cnt != 0) cnt <= cnt - 1;
    end

    assign cdone = (cnt == 1) || force_done;

    task automatic check(input string nm, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cstart) begin
                n_start++;
                if (exp_z.size() == 0) begin
                    check("unexpected_start", 1, 0);
                end else begin
`ifdef SGEN_PHASE_DITHER_EN
                    int e, d;
                    e = exp_z.pop_front();
                    d = int'($signed(cz)) - e;
                    check("cordic_z_window", (d >= -2 && d <= 2) ? 1 : 0, 1);
`else
                    check("cordic_z", $signed(cz), exp_z.pop_front());
`endif
                end
            end
            if (o_valid) begin
                n_valid++;
                if (chk_period && last_valid >= 0)
                    check("period", cyc - last_valid, LAT + 3);
                last_valid = cyc;
                if (exp_sin.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    check("sin", $signed(o_sin), exp_sin.pop_front());
`ifdef SGEN_PHASE_DITHER_EN
                    void'(exp_cos.pop_front());
`else
                    check("cos", $signed(o_cos), exp_cos.pop_front());
`endif
                end
            end
        end
    end

    task automatic push(input int z, input int s, input int c);
        exp_z.push_back(z);
        exp_sin.push_back(s);
        exp_cos.push_back(c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        ena   = 1'b0;
        exp_z.delete();
        exp_sin.delete();
        exp_cos.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_samples(input int n);
        int target;
        target = n_valid + n;
        ena = 1'b1;
        for (int i = 0; i < n * 40; i++) begin
            @(negedge clk);
            #1;
            if (n_valid >= target) break;
        end
        ena = 1'b0;
        check("valid_count", n_valid, target);
    endtask

    task automatic wait_start();
        int base;
        base = n_start;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (n_start > base) break;
        end
        check("start_seen", n_start, base + 1);
    endtask

    initial begin
        rst_n = 1'b0;
        ena = 1'b0;
        fcw = '0;
        stub_x = '0;
        stub_y = '0;
        force_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_z", $signed(cz), 0);
        check("rst_start", cstart, 0);
        check("rst_valid", o_valid, 0);
        check("rst_sin", $signed(o_sin), 0);
        check("rst_cos", $signed(o_cos), 0);
        check("cordic_x", $signed(cx), 4194304);
        check("cordic_y", $signed(cy), 0);

        // fcw = 0: constant zero angle, samples every LAT+3 cycles
        stub_x = 24'd1000;
        stub_y = -24'sd2000;
        repeat (3) push(0, -2000, 1000);
        chk_period = 1'b1;
        last_valid = -1;
        rst_n = 1'b1;
        run_samples(3);
        chk_period = 1'b0;

        // quarter-turn steps, acc wraps after four samples
        do_reset();
        fcw = 32'h4000_0000;
        stub_x = 24'd5000;
        stub_y = 24'd7;
        push(0, 7, 5000);
        push(25736, 7, 5000);
        push(0, 7, -5000);
        push(-25736, 7, 5000);
        push(0, 7, 5000);
        run_samples(5);

        // saturated negation on a folded sample
        do_reset();
        stub_x = 24'h80_0000;
        stub_y = -24'sd3;
        push(0, -3, -8388608);
        push(25736, -3, -8388608);
        push(0, -3, 8388607);
        run_samples(3);

        // enable drops during WAIT: current sample completes, nothing more
        do_reset();
        stub_x = 24'd100;
        stub_y = 24'd50;
        push(0, 50, 100);
        begin
            int vb, sb;
            vb = n_valid;
            sb = n_start;
            ena = 1'b1;
            wait_start();
            repeat (2) @(negedge clk);
            #1;
            ena = 1'b0;
            repeat (40) @(negedge clk);
            #1;
            check("ena_drop_valid", n_valid - vb, 1);
            check("ena_drop_start", n_start - sb, 1);
            check("ena_drop_queue", exp_sin.size(), 0);
        end

        // reset in WAIT with a late done: no sample, clean restart
        do_reset();
        stub_x = 24'd300;
        stub_y = -24'sd1;
        exp_z.push_back(0);
        begin
            int vb;
            vb = n_valid;
            ena = 1'b1;
            wait_start();
            repeat (2) @(negedge clk);
            #1;
            rst_n = 1'b0;
            ena = 1'b0;
            @(negedge clk);
            #1;
            rst_n = 1'b1;
            force_done = 1'b1;
            @(negedge clk);
            #1;
            force_done = 1'b0;
            check("mid_rst_valid", o_valid, 0);
            check("mid_rst_sin", $signed(o_sin), 0);
            check("mid_rst_cos", $signed(o_cos), 0);
            check("mid_rst_z", $signed(cz), 0);
            repeat (20) @(negedge clk);
            #1;
            check("mid_rst_no_valid", n_valid - vb, 0);
        end
        push(0, -1, 300);
        push(25736, -1, 300);
        run_samples(2);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_z.size() + exp_sin.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
